// File: rtl/tb_run_sequencer.sv
// tb_run_sequencer: host-driven regression run controller; loads imem/dmem, runs core until signature or timeout, drains, dumps dmem
module tb_run_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int DRAIN_CYCLES = 5,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [DATA_WIDTH-1:0] SIGNATURE = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic                         ld_sel,
  input  logic                         ld_last,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         imem_we,
  output logic                         dmem_we,
  output logic                         dmem_re,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata,
  output logic                         core_rst,
  input  logic                         snp_we,
  input  logic [ADDR_WIDTH-1:0]        snp_addr,
  input  logic [DATA_WIDTH-1:0]        snp_wdata,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [DATA_WIDTH-1:0]        dump_data,
  output logic                         dump_last,
  output logic                         busy,
  output logic                         pass,
  output logic                         timeout,
  output logic                         overflow
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DUMP, DONE} state_t;
  state_t state;
  logic [CW-1:0] icnt, dcnt, idx, sel_cnt;
  logic [TW-1:0] cyc;
  logic [DW-1:0] dcyc;
  logic rd_pend, hs, sel_full, hit;
  assign hs = ld_valid && ld_ready;
  assign sel_cnt = ld_sel ? dcnt : icnt;
  assign sel_full = sel_cnt == CW'(MEM_DEPTH);
  assign hit = snp_we && (snp_addr >> 2) == '0 && snp_wdata == SIGNATURE;
  assign mem_addr = state == LOAD ? sel_cnt[AW-1:0] : idx[AW-1:0];
  assign mem_wdata = ld_data;
  assign imem_we = hs && !ld_sel && !sel_full;
  assign dmem_we = hs && ld_sel && !sel_full;
  assign busy = state != IDLE && state != DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      core_rst <= 1'b1;
      ld_ready <= 1'b0;
      dmem_re <= 1'b0;
      rd_pend <= 1'b0;
      dump_valid <= 1'b0;
      dump_last <= 1'b0;
      dump_data <= '0;
      pass <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
      icnt <= '0;
      dcnt <= '0;
      idx <= '0;
      cyc <= '0;
      dcyc <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          ld_ready <= 1'b1;
          pass <= 1'b0;
          timeout <= 1'b0;
          overflow <= 1'b0;
          icnt <= '0;
          dcnt <= '0;
        end
        LOAD: if (hs) begin
          if (sel_full) overflow <= 1'b1;
          else if (ld_sel) dcnt <= dcnt + 1'b1;
          else icnt <= icnt + 1'b1;
          if (ld_last) begin
            state <= RUN;
            ld_ready <= 1'b0;
            core_rst <= 1'b0;
            cyc <= '0;
          end
        end
        RUN: begin
          cyc <= cyc + 1'b1;
          if (hit) begin
            pass <= 1'b1;
            state <= DRAIN;
            dcyc <= '0;
          end else if (cyc == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state <= DUMP;
            core_rst <= 1'b1;
            idx <= '0;
            dmem_re <= 1'b1;
          end
        end
        DRAIN: begin
          dcyc <= dcyc + 1'b1;
          if (dcyc == DW'(DRAIN_CYCLES - 1)) begin
            state <= DUMP;
            core_rst <= 1'b1;
            idx <= '0;
            dmem_re <= 1'b1;
          end
        end
        DUMP: begin
          dmem_re <= 1'b0;
          rd_pend <= dmem_re;
          if (rd_pend) begin
            dump_data <= dmem_rdata;
            dump_valid <= 1'b1;
            dump_last <= idx == CW'(MEM_DEPTH - 1);
          end
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            dump_last <= 1'b0;
            if (dump_last) state <= DONE;
            else begin
              idx <= idx + 1'b1;
              dmem_re <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tb_run_sequencer.sv
// tb_tb_run_sequencer: scoreboard bench for tb_run_sequencer with small memories and a short timeout
module tb_tb_run_sequencer;
  localparam int D = 16;
  localparam int AW = 4;
  localparam logic [31:0] SIG = 32'hDEADBEEF;
  typedef struct packed {logic sel; logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, rst = 1, start = 0, ld_valid = 0, ld_sel = 0, ld_last = 0, dump_ready = 0, snp_we = 0;
  logic [31:0] ld_data = 0, snp_addr = 0, snp_wdata = 0, dmem_rdata = 0;
  logic ld_ready, imem_we, dmem_we, dmem_re, core_rst, dump_valid, dump_last, busy, pass, timeout, overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, dump_data;
  logic [31:0] dmem [D];
  logic [31:0] exp_dmem [D];
  wr_t wr_q[$];
  logic [31:0] dq[$];
  int total = 0, bad = 0;

  tb_run_sequencer #(.MEM_DEPTH(D), .DRAIN_CYCLES(5), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_sel(ld_sel), .ld_last(ld_last), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .imem_we(imem_we),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata), .core_rst(core_rst), .snp_we(snp_we),
    .snp_addr(snp_addr), .snp_wdata(snp_wdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .pass(pass), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < D; i++) dmem[i] <= 32'hA000_0000 + i;
    else begin
      if (dmem_we) dmem[mem_addr] <= mem_wdata;
      if (dmem_re) dmem_rdata <= dmem[mem_addr];
    end
  end

  task automatic do_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic load(input int ni, input int nd);
    int n, ci, cd, c;
    logic sel, w;
    logic [31:0] d;
    wr_t e, g;
    n = ni + nd;
    ci = 0;
    cd = 0;
    for (int k = 0; k < n; k++) begin
      sel = k >= ni;
      c = sel ? cd : ci;
      w = c < D;
      d = $urandom;
      if (w) begin
        wr_q.push_back('{sel: sel, a: AW'(c), d: d});
        if (sel) exp_dmem[c] = d;
      end
      if (sel) cd++; else ci++;
      @(negedge clk);
      ld_valid = 1;
      ld_sel = sel;
      ld_data = d;
      ld_last = k == n - 1;
      #1;
      total++;
      if (imem_we || dmem_we) begin
        g = '{sel: dmem_we, a: mem_addr, d: mem_wdata};
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL load_word k=%0d strobe i=%b d=%b got addr=%0d, required no strobe", k, imem_we, dmem_we, mem_addr);
        end else begin
          e = wr_q.pop_front();
          if (g !== e || (imem_we && dmem_we) || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_word k=%0d got sel=%b addr=%0d data=%h rdy=%b, required sel=%b addr=%0d data=%h rdy=1", k, g.sel, g.a, g.d, ld_ready, e.sel, e.a, e.d);
          end
        end
      end else if (w) begin
        bad++;
        wr_q.delete();
        $display("FAIL load_word k=%0d got no strobe, required write at %0d", k, c);
      end
    end
    total++;
    if (core_rst !== 1'b1) begin bad++; $display("FAIL load_core_rst got %b during last load cycle, required 1", core_rst); end
    @(negedge clk);
    ld_valid = 0;
    ld_last = 0;
    total++;
    if (core_rst !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL run_entry got core_rst=%b busy=%b, required 0 1", core_rst, busy); end
  endtask

  task automatic dump_all(input int stall_at);
    int idx, stall;
    logic done;
    logic [31:0] held, e;
    idx = 0;
    stall = 0;
    done = 0;
    held = 0;
    dump_ready = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (dmem_re) begin
        dq.push_back(exp_dmem[idx % D]);
        total++;
        if (mem_addr !== AW'(idx) || dump_valid) begin
          bad++;
          $display("FAIL dump_read got addr=%0d valid=%b, required addr=%0d valid=0", mem_addr, dump_valid, idx);
        end
      end
      if (dump_valid) begin
        if (idx == stall_at && stall < 3) begin
          if (stall > 0) begin
            total++;
            if (dump_data !== held) begin bad++; $display("FAIL dump_stall got %h, required held %h", dump_data, held); end
          end
          held = dump_data;
          stall++;
          dump_ready = 0;
        end else begin
          dump_ready = 1;
          total++;
          if (dq.size() == 0) begin
            bad++;
            $display("FAIL dump_word idx=%0d got %h with no read issued", idx, dump_data);
          end else begin
            e = dq.pop_front();
            if (dump_data !== e || dump_last !== (idx == D - 1)) begin
              bad++;
              $display("FAIL dump_word idx=%0d got %h last=%b, required %h last=%b", idx, dump_data, dump_last, e, idx == D - 1);
            end
          end
          done = idx == D - 1;
          idx++;
        end
      end
      @(negedge clk);
    end
    dump_ready = 0;
    total++;
    if (!done) begin bad++; $display("FAIL dump_budget got %0d words, required %0d", idx, D); end
    total++;
    if (busy !== 1'b0 || dump_valid !== 1'b0 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL dump_done got busy=%b valid=%b core_rst=%b, required 0 0 1", busy, dump_valid, core_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < D; i++) exp_dmem[i] = 32'hA000_0000 + i;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (core_rst !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctl got core_rst=%b busy=%b, required 1 0", core_rst, busy); end
    total++;
    if ({ld_ready, imem_we, dmem_we, dmem_re, dump_valid, dump_last} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got %b, required 000000", {ld_ready, imem_we, dmem_we, dmem_re, dump_valid, dump_last});
    end
    total++;
    if ({pass, timeout, overflow} !== 3'b0) begin bad++; $display("FAIL reset_flags got %b, required 000", {pass, timeout, overflow}); end
    @(negedge clk) rst = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || core_rst !== 1'b1) begin bad++; $display("FAIL idle_hold got busy=%b core_rst=%b, required 0 1", busy, core_rst); end
  endtask

  task automatic test_pass();
    int low;
    do_start();
    load(4, 2);
    start = 1;
    snp_we = 1;
    snp_addr = 32'h4;
    snp_wdata = SIG;
    @(negedge clk);
    start = 0;
    total++;
    if (ld_ready !== 1'b0 || core_rst !== 1'b0 || pass !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored got ld_ready=%b core_rst=%b pass=%b, required 0 0 0", ld_ready, core_rst, pass);
    end
    snp_addr = 32'h0;
    @(negedge clk);
    snp_we = 0;
    total++;
    if (pass !== 1'b1) begin bad++; $display("FAIL pass_set got %b, required 1", pass); end
    low = 0;
    for (int j = 0; j < 5; j++) begin
      if (!core_rst && !dmem_re) low++;
      snp_we = j == 2;
      @(negedge clk);
    end
    snp_we = 0;
    total++;
    if (low !== 5) begin bad++; $display("FAIL drain_len got %0d running cycles, required 5", low); end
    total++;
    if (core_rst !== 1'b1 || dmem_re !== 1'b1 || mem_addr !== '0) begin
      bad++;
      $display("FAIL dump_start got core_rst=%b re=%b addr=%0d, required 1 1 0", core_rst, dmem_re, mem_addr);
    end
    dump_all(7);
    total++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL done_flags got pass=%b timeout=%b, required 1 0", pass, timeout); end
  endtask

  task automatic test_timeout();
    int low;
    do_start();
    load(2, 1);
    low = 0;
    for (int j = 0; j < 20; j++) begin
      snp_we = j < 2;
      snp_addr = j == 0 ? 32'h4 : 32'h0;
      snp_wdata = j == 1 ? 32'h1234_5678 : SIG;
      if (!core_rst && !timeout) low++;
      @(negedge clk);
    end
    snp_we = 0;
    total++;
    if (low !== 20) begin bad++; $display("FAIL timeout_len got %0d run cycles, required 20", low); end
    total++;
    if (timeout !== 1'b1 || pass !== 1'b0 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL timeout_flags got timeout=%b pass=%b core_rst=%b, required 1 0 1", timeout, pass, core_rst);
    end
    dump_all(-1);
  endtask

  task automatic test_hit_at_expiry();
    do_start();
    load(1, 0);
    repeat (19) @(negedge clk);
    snp_we = 1;
    snp_addr = 32'h0;
    snp_wdata = SIG;
    @(negedge clk);
    snp_we = 0;
    total++;
    if (pass !== 1'b1 || timeout !== 1'b0 || core_rst !== 1'b0) begin
      bad++;
      $display("FAIL hit_at_expiry got pass=%b timeout=%b core_rst=%b, required 1 0 0", pass, timeout, core_rst);
    end
    dump_all(-1);
  endtask

  task automatic test_overflow();
    do_start();
    load(D + 1, 0);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow got %b, required 1", overflow); end
    #2 rst = 1;
    #1;
    total++;
    if (core_rst !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got core_rst=%b busy=%b overflow=%b ld_ready=%b, required 1 0 0 0", core_rst, busy, overflow, ld_ready);
    end
    @(negedge clk) rst = 0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_hit_at_expiry();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
